// File: rtl/user_gpio_bank_if.sv
// user_gpio_bank_if: Wishbone classic slave bus bundle for the GPIO bank
interface user_gpio_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_gpio_bank.sv
// user_gpio_bank: Wishbone GPIO bank with out/oeb registers, synchronised inputs and edge IRQs
module user_gpio_bank #(
  parameter int                NPADS     = 16,
  parameter logic [31:0]       BASE_ADDR = 32'h3000_0000,
  parameter logic [NPADS-1:0]  OEB_RESET = '1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  user_gpio_bank_if.slave    wb,
  input  logic [NPADS-1:0]   io_in,
  output logic [NPADS-1:0]   io_out,
  output logic [NPADS-1:0]   io_oeb,
  output logic               irq
);
  logic [NPADS-1:0] out_q, out_d, oeb_q, oeb_d, rise_q, rise_d, fall_q, fall_d, st_q, st_d;
  logic [NPADS-1:0] s1_q, s2_q, s3_q, ev, wm, wd, rsel;
  logic [31:0] bm, dat_q;
  logic [2:0] off;
  logic ack_q, hit, req, wr, unused_bits;
  assign bm = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}}, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
  assign wm = bm[NPADS-1:0];
  assign wd = wb.wbs_dat_i[NPADS-1:0] & wm;
  assign off = wb.wbs_adr_i[4:2];
  assign hit = wb.wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
  assign wr = req & wb.wbs_we_i;
  assign unused_bits = ^{bm, wb.wbs_dat_i, wb.wbs_adr_i[1:0]};
  always_comb begin
    out_d = !wr ? out_q :
            off == 3'd0 ? (out_q & ~wm) | wd :
            off == 3'd6 ? out_q | wd :
            off == 3'd7 ? out_q & ~wd : out_q;
    oeb_d = wr && off == 3'd1 ? (oeb_q & ~wm) | wd : oeb_q;
    rise_d = wr && off == 3'd3 ? (rise_q & ~wm) | wd : rise_q;
    fall_d = wr && off == 3'd4 ? (fall_q & ~wm) | wd : fall_q;
    ev = (s2_q & ~s3_q & rise_q) | (~s2_q & s3_q & fall_q);
    // a new event wins over a same-cycle write-1-to-clear
    st_d = (wr && off == 3'd5 ? st_q & ~wd : st_q) | ev;
    case (off)
      3'd0: rsel = out_q;
      3'd1: rsel = oeb_q;
      3'd2: rsel = s2_q;
      3'd3: rsel = rise_q;
      3'd4: rsel = fall_q;
      3'd5: rsel = st_q;
      default: rsel = '0;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      out_q  <= '0;
      oeb_q  <= OEB_RESET;
      rise_q <= '0;
      fall_q <= '0;
      st_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      st_q   <= st_d;
      s1_q   <= io_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      ack_q  <= req;
      dat_q  <= req && !wb.wbs_we_i ? 32'(rsel) : '0;
    end
  end
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_out = out_q;
  assign io_oeb = oeb_q;
  assign irq = |st_q;
endmodule

// File: tb/tb_user_gpio_bank.sv
// tb_user_gpio_bank: directed stimulus against a register-level behavioural model plus literal checks
module tb_user_gpio_bank;
  localparam int NP = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
  logic [NP-1:0] io_in = '0;
  logic [NP-1:0] io_out, io_oeb;
  logic irq;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  user_gpio_bank_if bus();
  user_gpio_bank #(.NPADS(NP), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  logic [NP-1:0] m_out, m_oeb, m_rise, m_fall, m_st;
  logic [NP-1:0] samp [3];
  logic m_ack;
  logic [31:0] m_dat;
  function automatic logic [31:0] m_rd(input logic [2:0] o);
    case (o)
      3'd0: return 32'(m_out);
      3'd1: return 32'(m_oeb);
      3'd2: return 32'(samp[1]);
      3'd3: return 32'(m_rise);
      3'd4: return 32'(m_fall);
      3'd5: return 32'(m_st);
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    logic req;
    logic [NP-1:0] ev, bm, wd;
    logic [31:0] b32;
    if (!rst_n) begin
      m_out = '0; m_oeb = '1; m_rise = '0; m_fall = '0; m_st = '0;
      samp[0] = '0; samp[1] = '0; samp[2] = '0;
      m_ack = 1'b0; m_dat = '0;
    end else begin
      req = bus.wbs_cyc_i && bus.wbs_stb_i && bus.wbs_adr_i[31:5] == BASE[31:5] && !m_ack;
      ev = '0;
      for (int i = 0; i < NP; i++)
        if ((samp[1][i] && !samp[2][i] && m_rise[i]) || (!samp[1][i] && samp[2][i] && m_fall[i])) ev[i] = 1'b1;
      m_dat = req && !bus.wbs_we_i ? m_rd(bus.wbs_adr_i[4:2]) : 32'h0;
      b32 = '0;
      for (int b = 0; b < 4; b++) if (bus.wbs_sel_i[b]) b32[8*b +: 8] = 8'hFF;
      bm = b32[NP-1:0];
      wd = bus.wbs_dat_i[NP-1:0] & bm;
      if (req && bus.wbs_we_i)
        case (bus.wbs_adr_i[4:2])
          3'd0: m_out = (m_out & ~bm) | wd;
          3'd1: m_oeb = (m_oeb & ~bm) | wd;
          3'd3: m_rise = (m_rise & ~bm) | wd;
          3'd4: m_fall = (m_fall & ~bm) | wd;
          3'd5: m_st = m_st & ~wd;
          3'd6: m_out = m_out | wd;
          3'd7: m_out = m_out & ~wd;
          default: ;
        endcase
      m_st = m_st | ev;
      samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = io_in;
      m_ack = req;
    end
  end
  always @(negedge clk) if (go) begin
    chk("m_ack", 32'(bus.wbs_ack_o), 32'(m_ack));
    chk("m_dat", bus.wbs_dat_o, m_dat);
    chk("m_io_out", 32'(io_out), 32'(m_out));
    chk("m_io_oeb", 32'(io_oeb), 32'(m_oeb));
    chk("m_irq", 32'(irq), 32'(|m_st));
  end
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel,
                    output logic [31:0] rd, output logic got);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = d; bus.wbs_sel_i = sel;
    got = 1'b0; rd = 'x;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin got = 1'b1; rd = bus.wbs_dat_o; end
    end
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask
  task automatic wr(input string name, input logic [2:0] o, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r; logic g;
    wb(1'b1, BASE + 32'(o) * 4, d, sel, r, g);
    chk(name, 32'(g), 32'd1);
  endtask
  task automatic rdc(input string name, input logic [2:0] o, input logic [31:0] exp);
    logic [31:0] r; logic g;
    wb(1'b0, BASE + 32'(o) * 4, 32'h0, 4'hF, r, g);
    chk(name, g ? r : 32'hxxxx_xxxx, exp);
  endtask
  initial begin
    logic [31:0] rst_exp [8];
    logic [3:0] acks;
    rst_exp = '{32'h0, 32'h0000FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; go = 1'b1;
    chk("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) rdc($sformatf("rst_rd%0d", i), 3'(i), rst_exp[i]);
    wr("wr_out", 3'd0, 32'h0000A5A5, 4'b0001);
    rdc("out_a5", 3'd0, 32'h000000A5);
    chk("io_out_a5", 32'(io_out), 32'h00A5);
    wr("wr_set", 3'd6, 32'h00000F00, 4'hF);
    rdc("out_set", 3'd0, 32'h00000FA5);
    wr("wr_clr", 3'd7, 32'h00000005, 4'hF);
    rdc("out_clr", 3'd0, 32'h00000FA0);
    wr("wr_out_all", 3'd0, 32'hFFFFFFFF, 4'hF);
    rdc("out_npads", 3'd0, 32'h0000FFFF);
    rdc("set_reads0", 3'd6, 32'h0);
    wr("wr_in", 3'd2, 32'hFFFFFFFF, 4'hF);
    rdc("in_ignored", 3'd2, 32'h0);
    wr("wr_rise0", 3'd3, 32'h1, 4'hF);
    io_in[0] = 1'b1;
    @(posedge clk); #1 chk("irq_k", 32'(irq), 32'd0);
    @(posedge clk); #1 chk("irq_k1", 32'(irq), 32'd0);
    @(posedge clk); #1 chk("irq_k2", 32'(irq), 32'd1);
    rdc("in_pin0", 3'd2, 32'h1);
    rdc("st_pin0", 3'd5, 32'h1);
    wr("w1c0", 3'd5, 32'h1, 4'hF);
    rdc("st_clr0", 3'd5, 32'h0);
    chk("irq_clr0", 32'(irq), 32'd0);
    io_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    rdc("st_nofall", 3'd5, 32'h0);
    wr("wr_rise9", 3'd3, 32'h9, 4'hF);
    io_in[3] = 1'b1;
    @(posedge clk); @(posedge clk);
    wr("w1c3_race", 3'd5, 32'h8, 4'b0001);
    rdc("st_setwins", 3'd5, 32'h8);
    wr("w1c3", 3'd5, 32'h8, 4'hF);
    rdc("st_clr3", 3'd5, 32'h0);
    wr("wr_fall8", 3'd4, 32'h8, 4'hF);
    io_in[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("irq_fall3", 32'(irq), 32'd1);
    rdc("st_fall3", 3'd5, 32'h8);
    wr("w1c3b", 3'd5, 32'h8, 4'hF);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = BASE;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1 acks[i] = bus.wbs_ack_o; end
    @(negedge clk); bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    chk("held_ack", 32'(acks), 32'b0101);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oow_ack", 32'(bus.wbs_ack_o), 32'd0);
      chk("oow_dat", bus.wbs_dat_o, 32'h0);
    end
    @(negedge clk); bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    wr("wr_oeb", 3'd1, 32'h00F0, 4'hF);
    wr("clr_all", 3'd7, 32'hFFFF, 4'hF);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h5678; bus.wbs_sel_i = 4'hF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_noack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_io_oeb", 32'(io_oeb), 32'hFFFF);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; rst_n = 1'b1;
    rdc("rst_out0", 3'd0, 32'h0);
    rdc("rst_oeb", 3'd1, 32'h0000FFFF);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
